// File: rtl/vga_display_timing_pkg.sv
// Shared constants for the 640x480@60 Hz raster generator.
// The DEF_ values are the defaults of the top-level parameters.
package vga_display_timing_pkg;

  localparam int unsigned COUNT_W         = 10;
  localparam int unsigned FRAME_W         = 8;

  localparam int unsigned DEF_CLK_DIV     = 4;
  localparam int unsigned DEF_H_TOTAL     = 800;
  localparam int unsigned DEF_H_SYNC      = 96;
  localparam int unsigned DEF_H_ACT_START = 144;
  localparam int unsigned DEF_H_ACT_END   = 783;
  localparam int unsigned DEF_V_TOTAL     = 525;
  localparam int unsigned DEF_V_SYNC      = 2;
  localparam int unsigned DEF_V_ACT_START = 35;
  localparam int unsigned DEF_V_ACT_END   = 514;

endpackage

// File: rtl/vga_display_timing_if.sv
// Raster timing bundle: the generator drives it (master) and renderers or the connector consume it (slave).
interface vga_display_timing_if;
  import vga_display_timing_pkg::*;

  logic               pix_en;
  logic [COUNT_W-1:0] hCount;
  logic [COUNT_W-1:0] vCount;
  logic               hSync;
  logic               vSync;
  logic               bright;
  logic               frame_tick;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    output pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, frame_count
  );

  modport slave (
    input  pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, frame_count
  );

endinterface

// File: rtl/raster_axis_counter.sv
// One raster axis: a wrapping position counter with a registered active-low sync.
// The active decode is exported from the next count so the parent can register it in step with the count.
module raster_axis_counter
  import vga_display_timing_pkg::*;
#(
  parameter int unsigned TERM      = DEF_H_TOTAL - 1,
  parameter int unsigned SYNC      = DEF_H_SYNC,
  parameter int unsigned ACT_START = DEF_H_ACT_START,
  parameter int unsigned ACT_END   = DEF_H_ACT_END
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  output logic [COUNT_W-1:0] count,
  output logic               sync,
  output logic               active_nxt_c,
  output logic               wrap_c
);

  logic [COUNT_W-1:0] count_nxt;

  // Next position and the decodes that must land on the same edge as it.
  always_comb begin
    wrap_c    = (count == COUNT_W'(TERM));
    count_nxt = count;
    if (step) begin
      count_nxt = wrap_c ? '0 : count + COUNT_W'(1);
    end
    active_nxt_c = (count_nxt >= COUNT_W'(ACT_START)) && (count_nxt <= COUNT_W'(ACT_END));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sync  <= 1'b0;
    end else begin
      count <= count_nxt;
      sync  <= (count_nxt >= COUNT_W'(SYNC));
    end
  end

endmodule

// File: rtl/vga_display_timing.sv
// 640x480@60 Hz raster timing: pixel-enable divider, horizontal/vertical sweep,
// visible-window flag and a once-per-frame strobe at the start of vertical blanking.
module vga_display_timing
  import vga_display_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_ACT_START = DEF_H_ACT_START,
  parameter int unsigned H_ACT_END   = DEF_H_ACT_END,
  parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_ACT_START = DEF_V_ACT_START,
  parameter int unsigned V_ACT_END   = DEF_V_ACT_END
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_display_timing_if.master vga
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0]   div;
  logic               step_c;
  logic               v_step_c;
  logic               tick_c;
  logic               h_wrap_c;
  logic               v_wrap_unused_c;
  logic               h_act_nxt_c;
  logic               v_act_nxt_c;
  logic [COUNT_W-1:0] h_count;
  logic [COUNT_W-1:0] v_count;
  logic               h_sync;
  logic               v_sync;
  logic               pix_en;
  logic               bright;
  logic               frame_tick;
  logic [FRAME_W-1:0] frame_count;

  // The step decode is the same edge at which the registered pix_en rises.
  always_comb begin
    step_c   = (div == DIV_W'(CLK_DIV - 1));
    v_step_c = step_c & h_wrap_c;
    tick_c   = v_step_c && (v_count == COUNT_W'(V_ACT_END));
  end

  raster_axis_counter #(
    .TERM      (H_TOTAL - 1),
    .SYNC      (H_SYNC),
    .ACT_START (H_ACT_START),
    .ACT_END   (H_ACT_END)
  ) u_h_axis (
    .clk          (clk),
    .rst          (rst),
    .step         (step_c),
    .count        (h_count),
    .sync         (h_sync),
    .active_nxt_c (h_act_nxt_c),
    .wrap_c       (h_wrap_c)
  );

  raster_axis_counter #(
    .TERM      (V_TOTAL - 1),
    .SYNC      (V_SYNC),
    .ACT_START (V_ACT_START),
    .ACT_END   (V_ACT_END)
  ) u_v_axis (
    .clk          (clk),
    .rst          (rst),
    .step         (v_step_c),
    .count        (v_count),
    .sync         (v_sync),
    .active_nxt_c (v_act_nxt_c),
    .wrap_c       (v_wrap_unused_c)
  );

  // Divider, visible-window flag and frame strobe/counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      pix_en      <= 1'b0;
      bright      <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      div        <= div + DIV_W'(1);
      pix_en     <= step_c;
      bright     <= h_act_nxt_c & v_act_nxt_c;
      frame_tick <= tick_c;
      if (tick_c) begin
        frame_count <= frame_count + FRAME_W'(1);
      end
    end
  end

  assign vga.pix_en      = pix_en;
  assign vga.hCount      = h_count;
  assign vga.vCount      = v_count;
  assign vga.hSync       = h_sync;
  assign vga.vSync       = v_sync;
  assign vga.bright      = bright;
  assign vga.frame_tick  = frame_tick;
  assign vga.frame_count = frame_count;

endmodule

// File: tb/tb_vga_display_timing.sv
// Bench for vga_display_timing: a full-size instance for line-level timing and a
// shrunken raster instance so whole frames and the frame_count wrap fit in a short run.
module tb_vga_display_timing;
  import vga_display_timing_pkg::*;

  typedef struct packed {
    int unsigned cd, ht, hs, has, hae, vt, vs, vas, vae;
  } cfg_t;

  typedef struct packed {
    logic               pe;
    logic [COUNT_W-1:0] h;
    logic [COUNT_W-1:0] v;
    logic               hs;
    logic               vs;
    logic               br;
    logic               ft;
    logic [FRAME_W-1:0] fc;
  } obs_t;

  localparam cfg_t CFG_A = '{4, 800, 96, 144, 783, 525, 2, 35, 514};
  localparam cfg_t CFG_B = '{2, 10, 2, 3, 8, 8, 1, 2, 5};
  localparam int   E_END = 41400;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  vga_display_timing_if va ();
  vga_display_timing_if vb ();

  vga_display_timing dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (va)
  );

  vga_display_timing #(
    .CLK_DIV     (2),
    .H_TOTAL     (10),
    .H_SYNC      (2),
    .H_ACT_START (3),
    .H_ACT_END   (8),
    .V_TOTAL     (8),
    .V_SYNC      (1),
    .V_ACT_START (2),
    .V_ACT_END   (5)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (vb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs k clock edges after reset release, from closed-form raster arithmetic.
  function automatic obs_t model(input cfg_t c, input int unsigned k);
    obs_t        o;
    int unsigned n, h, v, frame, off;
    n     = k / c.cd;
    h     = n % c.ht;
    v     = (n / c.ht) % c.vt;
    frame = c.ht * c.vt;
    off   = (c.vae + 1) * c.ht;
    o.pe  = (k != 0) && (k % c.cd == 0);
    o.h   = COUNT_W'(h);
    o.v   = COUNT_W'(v);
    o.hs  = (h >= c.hs);
    o.vs  = (v >= c.vs);
    o.br  = (h >= c.has) && (h <= c.hae) && (v >= c.vas) && (v <= c.vae);
    o.ft  = o.pe && (n % frame == off);
    o.fc  = (n >= off) ? FRAME_W'((n - off) / frame + 1) : '0;
    return o;
  endfunction

  task automatic compare_obs(input string tag, input obs_t act, input obs_t exp);
    check({tag, ".pix_en"},      32'(act.pe), 32'(exp.pe));
    check({tag, ".hCount"},      32'(act.h),  32'(exp.h));
    check({tag, ".vCount"},      32'(act.v),  32'(exp.v));
    check({tag, ".hSync"},       32'(act.hs), 32'(exp.hs));
    check({tag, ".vSync"},       32'(act.vs), 32'(exp.vs));
    check({tag, ".bright"},      32'(act.br), 32'(exp.br));
    check({tag, ".frame_tick"},  32'(act.ft), 32'(exp.ft));
    check({tag, ".frame_count"}, 32'(act.fc), 32'(exp.fc));
  endtask

  int unsigned k_a = 0;
  int unsigned k_b = 0;

  // Per-cycle compare of both instances against the model.
  always @(posedge clk) begin
    obs_t oa, ob;
    k_a = rst_a ? 0 : k_a + 1;
    k_b = rst_b ? 0 : k_b + 1;
    #1;
    oa = {va.pix_en, va.hCount, va.vCount, va.hSync, va.vSync, va.bright, va.frame_tick, va.frame_count};
    ob = {vb.pix_en, vb.hCount, vb.vCount, vb.hSync, vb.vSync, vb.bright, vb.frame_tick, vb.frame_count};
    compare_obs("a", oa, model(CFG_A, k_a));
    compare_obs("b", ob, model(CFG_B, k_b));
  end

  initial begin
    int e;
    int hs_low, vs_low2, vs_low3, br_row5, br_row6;
    int tick_cnt, last_tick, rel_b;
    hs_low = 0; vs_low2 = 0; vs_low3 = 0; br_row5 = 0; br_row6 = 0;
    tick_cnt = 0; last_tick = 0; rel_b = -1;

    repeat (3) @(posedge clk);
    #1;
    check("a.reset_hCount", 32'(va.hCount), 0);
    check("a.reset_hSync",  32'(va.hSync),  0);
    check("a.reset_pix_en", 32'(va.pix_en), 0);
    check("b.reset_frame_count", 32'(vb.frame_count), 0);

    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (e = 1; e <= E_END; e++) begin
      @(posedge clk);
      #1;
      // full-size instance: first pixel, line wrap, hSync width
      if (e == 3) begin
        check("a.pix_en_e3", 32'(va.pix_en), 0);
        check("a.hCount_e3", 32'(va.hCount), 0);
      end
      if (e == 4) begin
        check("a.first_pix_en", 32'(va.pix_en), 1);
        check("a.first_hCount", 32'(va.hCount), 1);
      end
      if (e == 8) check("a.hCount_e8", 32'(va.hCount), 2);
      if (e == 3199) begin
        check("a.hCount_eol", 32'(va.hCount), 799);
        check("a.vCount_eol", 32'(va.vCount), 0);
      end
      if (e == 3200) begin
        check("a.hCount_wrap", 32'(va.hCount), 0);
        check("a.vCount_wrap", 32'(va.vCount), 1);
        check("a.pix_en_wrap", 32'(va.pix_en), 1);
      end
      if (e == 3583) check("a.hSync_last_low", 32'(va.hSync), 0);
      if (e == 3584) check("a.hSync_first_high", 32'(va.hSync), 1);
      if (e >= 3200 && e < 6400 && va.hSync == 1'b0) hs_low++;
      if (e == 6399) check("a.hSync_low_clks", 32'(hs_low), 384);
      if (e == 8000) begin
        check("a.hCount_pre_rst", 32'(va.hCount), 400);
        check("a.vCount_pre_rst", 32'(va.vCount), 2);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("a.async_rst_hCount", 32'(va.hCount), 0);
        check("a.async_rst_vCount", 32'(va.vCount), 0);
        check("a.async_rst_hSync",  32'(va.hSync),  0);
      end
      if (e == 8002) begin
        @(negedge clk);
        rst_a = 1'b0;
      end
      if (e == 8006) begin
        check("a.restart_pix_en", 32'(va.pix_en), 1);
        check("a.restart_hCount", 32'(va.hCount), 1);
        check("a.restart_vCount", 32'(va.vCount), 0);
      end

      // small instance: visible window edges, vSync width, frame strobe
      if (e == 2)  check("b.first_hCount", 32'(vb.hCount), 1);
      if (e == 44) check("b.bright_h2_v2", 32'(vb.bright), 0);
      if (e == 46) check("b.bright_h3_v2", 32'(vb.bright), 1);
      if (e == 56) check("b.bright_h8_v2", 32'(vb.bright), 1);
      if (e == 58) check("b.bright_h9_v2", 32'(vb.bright), 0);
      if (e >= 100 && e < 120 && vb.bright) br_row5++;
      if (e >= 120 && e < 140 && vb.bright) br_row6++;
      if (e == 140) begin
        check("b.bright_clks_row5", 32'(br_row5), 12);
        check("b.bright_clks_row6", 32'(br_row6), 0);
      end
      if (e >= 160 && e < 320 && !vb.vSync) vs_low2++;
      if (e >= 320 && e < 480 && !vb.vSync) vs_low3++;
      if (e == 480) begin
        check("b.vSync_low_frame1", 32'(vs_low2), 20);
        check("b.vSync_low_frame2", 32'(vs_low3), 20);
      end
      if (!rst_b && vb.frame_tick) begin
        tick_cnt++;
        check("b.tick_hCount", 32'(vb.hCount), 0);
        check("b.tick_vCount", 32'(vb.vCount), 6);
        if (rel_b >= 0)          check("b.tick_after_rst", 32'(e - rel_b), 120);
        else if (tick_cnt == 1)  check("b.first_tick_edge", 32'(e), 120);
        else                     check("b.tick_spacing", 32'(e - last_tick), 160);
        if (tick_cnt == 1)   check("b.frame_count_1",   32'(vb.frame_count), 1);
        if (tick_cnt == 2)   check("b.frame_count_2",   32'(vb.frame_count), 2);
        if (tick_cnt == 255) check("b.frame_count_255", 32'(vb.frame_count), 255);
        if (tick_cnt == 256) check("b.frame_count_wrap", 32'(vb.frame_count), 0);
        last_tick = e;
      end
      if (e == 41210) begin
        check("b.hCount_pre_rst", 32'(vb.hCount), 5);
        check("b.vCount_pre_rst", 32'(vb.vCount), 4);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("b.async_rst_frame_count", 32'(vb.frame_count), 0);
        check("b.async_rst_vCount",      32'(vb.vCount), 0);
      end
      if (e == 41212) begin
        @(negedge clk);
        rst_b = 1'b0;
        rel_b = e;
      end
    end

    check("b.ticks_before_rst", 32'(tick_cnt), 258);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
